vote_collector: RTL and testbench
=================================

VOTE_COLLECTOR -- requirements
Module: vote_collector

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of cycles a session stays in COLLECT before a forced close (legal range 8..1023).
REQ-002 clk  input  1  single clock; every flop is rising-edge triggered.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse that opens a voting session; honoured only in IDLE.
REQ-005 ballot_valid  input  1  ballot present on ballot_id/ballot_val.
REQ-006 ballot_id  input  3  voter index 0..6; value 7 is illegal.
REQ-007 ballot_val  input  1  1 = yes, 0 = no.
REQ-008 ballot_ready  output  1  high exactly while the state is COLLECT.
REQ-009 vote  output  7  assembled ballot vector; bit i holds voter i's vote.
REQ-010 yes_count  output  3  number of yes votes in vote (0..7).
REQ-011 pass  output  1  1 when yes_count >= 4.
REQ-012 result_valid  output  1  one-cycle pulse marking vote, yes_count, pass and timed_out as final.
REQ-013 timed_out  output  1  session closed by timeout with fewer than 7 ballots.
REQ-014 err  output  1  one-cycle pulse for each rejected ballot (duplicate id or id 7).

Function
REQ-015 States: IDLE, COLLECT, TALLY, DONE; each transition takes one clock edge.
REQ-016 IDLE -> COLLECT on start=1; in the same edge, clear vote, the received mask and the timeout counter.
REQ-017 In COLLECT, accept a ballot when ballot_valid & ballot_ready, setting vote[ballot_id]=ballot_val and received[ballot_id]=1.
REQ-018 A ballot with ballot_id=7, or whose id is already set in received, is dropped: vote is unchanged and err pulses on the next cycle.
REQ-019 COLLECT -> TALLY on the edge that accepts the ballot completing received=7'h7F.
REQ-020 COLLECT -> TALLY when the timeout counter reaches TIMEOUT-1; missing voters count as no and timed_out=1.
REQ-021 If the completing ballot and the timeout coincide, the ballot is accepted and timed_out=0.
REQ-022 TALLY computes yes_count as the popcount of vote and pass as (yes_count >= 4), registered at the TALLY -> DONE edge.
REQ-023 DONE asserts result_valid for exactly one cycle, then returns to IDLE.
REQ-024 Latency: result_valid is high 2 cycles after the edge that accepts the 7th ballot.
REQ-025 vote, yes_count, pass and timed_out hold their values from DONE until the next start.
REQ-026 start outside IDLE is ignored; ballot_valid outside COLLECT is ignored and does not pulse err.
REQ-027 The timeout counter width is clog2(TIMEOUT); it never wraps within a session.

Reset
REQ-028 rst_n low forces, asynchronously: IDLE, vote=0, received=0, counter=0, yes_count=0, pass=0, result_valid=0, timed_out=0, err=0, ballot_ready=0.
REQ-029 Reset mid-session discards all collected ballots; no result_valid is produced for the aborted session.

Structure
REQ-030 Package vote_pkg holds NUM_VOTERS=7, PASS_THRESHOLD=4 and the state enumeration; the RTL uses no literal 7 or 4.
REQ-031 Sub-module vote_popcount (7-bit in, 3-bit count out, purely combinational) is instantiated for TALLY.

Verification
REQ-032 start, then ids 0..6 with values 1,1,1,1,0,0,0 on consecutive cycles -> vote=7'h0F, yes_count=4, pass=1, result_valid 2 cycles after the last ballot.
REQ-033 Votes 1,1,1,0,0,0,0 -> yes_count=3, pass=0, timed_out=0.
REQ-034 Ids 0,2,4 all yes, then idle; TIMEOUT=16 -> timed_out=1, yes_count=3, pass=0, result_valid 2 cycles after counter=15.
REQ-035 Id 3 yes, then id 3 no, then id 7 -> two err pulses, vote[3] stays 1, received unchanged.
REQ-036 Assert rst_n low after 5 ballots -> all outputs 0 immediately; a following full session reports only its own votes.
REQ-037 7th ballot accepted on the same cycle the counter hits TIMEOUT-1 -> timed_out=0 and all 7 votes counted.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared constants and state encoding for the seven-voter ballot collector.
package vote_pkg;

  localparam int NUM_VOTERS     = 7;
  localparam int PASS_THRESHOLD = 4;
  localparam int ID_W           = $clog2(NUM_VOTERS + 32'd1);
  localparam int CNT_W          = $clog2(NUM_VOTERS + 32'd1);

  localparam logic [NUM_VOTERS-1:0] ALL_RECEIVED = {NUM_VOTERS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_TALLY   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of the assembled ballot vector.
module vote_popcount
  import vote_pkg::*;
(
  input  logic [NUM_VOTERS-1:0] bits,
  output logic [CNT_W-1:0]      count
);

  // Ripple-add each ballot bit into the running count.
  always_comb begin
    count = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_VOTERS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/vote_collector.sv
// Collects one ballot per voter per session, closes on completion or timeout,
// then publishes the tally with a one-cycle result_valid pulse.
module vote_collector
  import vote_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ballot_valid,
  input  logic [ID_W-1:0]       ballot_id,
  input  logic                  ballot_val,
  output logic                  ballot_ready,
  output logic [NUM_VOTERS-1:0] vote,
  output logic [CNT_W-1:0]      yes_count,
  output logic                  pass,
  output logic                  result_valid,
  output logic                  timed_out,
  output logic                  err
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 32'd1);
  localparam logic [NUM_VOTERS-1:0] ONE_HOT0 = NUM_VOTERS'(1'b1);

  state_t                  state_r, state_s;
  logic                    ballot_ready_r, result_valid_r, err_r;
  logic [NUM_VOTERS-1:0]   vote_r, received_r, id_mask_s;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic                    timed_out_r, pass_r;
  logic [CNT_W-1:0]        yes_count_r, popcnt_s;
  logic                    legal_s, dup_s, take_s, accept_s, reject_s;
  logic                    complete_s, timeout_s, opens_s;

  // Decode the ballot id into a one-hot mask; an illegal id yields an empty mask.
  always_comb begin
    id_mask_s = {NUM_VOTERS{1'b0}};
    if (ballot_id < ID_W'(NUM_VOTERS)) begin
      id_mask_s = ONE_HOT0 << ballot_id;
    end else begin
      id_mask_s = {NUM_VOTERS{1'b0}};
    end
  end

  assign legal_s    = |id_mask_s;
  assign dup_s      = |(received_r & id_mask_s);
  assign take_s     = ballot_valid & ballot_ready_r;
  assign accept_s   = take_s & legal_s & ~dup_s;
  assign reject_s   = take_s & ~(legal_s & ~dup_s);
  assign complete_s = accept_s & ((received_r | id_mask_s) == ALL_RECEIVED);
  assign timeout_s  = (tmo_cnt_r == TMO_LAST);
  assign opens_s    = (state_r == ST_IDLE) & start;

  // Next-state logic for the session sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_COLLECT;
        else       state_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (complete_s || timeout_s) state_s = ST_TALLY;
        else                         state_s = ST_COLLECT;
      end
      ST_TALLY: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register plus the registered handshake and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ballot_ready_r <= 1'b0;
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state_r        <= state_s;
      ballot_ready_r <= (state_s == ST_COLLECT);
      result_valid_r <= (state_r == ST_DONE);
      err_r          <= reject_s;
    end
  end

  // Ballot capture and session timer; the timer parks at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_r      <= {NUM_VOTERS{1'b0}};
      received_r  <= {NUM_VOTERS{1'b0}};
      tmo_cnt_r   <= {TMO_W{1'b0}};
      timed_out_r <= 1'b0;
    end else if (opens_s) begin
      vote_r      <= {NUM_VOTERS{1'b0}};
      received_r  <= {NUM_VOTERS{1'b0}};
      tmo_cnt_r   <= {TMO_W{1'b0}};
      timed_out_r <= 1'b0;
    end else if (ballot_ready_r) begin
      if (accept_s) begin
        vote_r     <= (vote_r & ~id_mask_s) | (ballot_val ? id_mask_s : {NUM_VOTERS{1'b0}});
        received_r <= received_r | id_mask_s;
      end
      if (!timeout_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
      end
      // A ballot completing the set on the timeout edge wins over the timeout.
      if (timeout_s && !complete_s) begin
        timed_out_r <= 1'b1;
      end
    end
  end

  vote_popcount u_popcount (
    .bits  (vote_r),
    .count (popcnt_s)
  );

  // Tally registers, loaded while leaving TALLY and held until the next session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yes_count_r <= {CNT_W{1'b0}};
      pass_r      <= 1'b0;
    end else if (opens_s) begin
      yes_count_r <= {CNT_W{1'b0}};
      pass_r      <= 1'b0;
    end else if (state_r == ST_TALLY) begin
      yes_count_r <= popcnt_s;
      pass_r      <= (popcnt_s >= CNT_W'(PASS_THRESHOLD));
    end
  end

  assign ballot_ready = ballot_ready_r;
  assign vote         = vote_r;
  assign yes_count    = yes_count_r;
  assign pass         = pass_r;
  assign result_valid = result_valid_r;
  assign timed_out    = timed_out_r;
  assign err          = err_r;

endmodule

// File: tb/tb_vote_collector.sv
// Randomized and directed bench for vote_collector against a session-level
// reference model (sets of received voters, cycle ages, close edges).
module tb_vote_collector;

  localparam int TMO = 16;
  localparam int NV  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ballot_valid = 1'b0;
  logic [2:0] ballot_id = 3'd0;
  logic       ballot_val = 1'b0;
  logic       ballot_ready;
  logic [6:0] vote;
  logic [2:0] yes_count;
  logic       pass;
  logic       result_valid;
  logic       timed_out;
  logic       err;

  vote_collector #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ballot_valid (ballot_valid),
    .ballot_id    (ballot_id),
    .ballot_val   (ballot_val),
    .ballot_ready (ballot_ready),
    .vote         (vote),
    .yes_count    (yes_count),
    .pass         (pass),
    .result_valid (result_valid),
    .timed_out    (timed_out),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a session is a set of received voters and their choices.
  int edge_cnt    = 0;
  int m_age       = 0;
  int m_rv_edge   = -10;
  int m_idle_edge = 0;
  bit m_collect   = 1'b0;
  bit m_tmo       = 1'b0;
  bit m_got [NV];
  bit m_val [NV];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_vote();
    int v = 0;
    for (int i = 0; i < NV; i++) if (m_got[i] && m_val[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int model_yes();
    int y = 0;
    for (int i = 0; i < NV; i++) if (m_got[i] && m_val[i]) y++;
    return y;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_got[i] = 1'b0;
      m_val[i] = 1'b0;
    end
  endtask

  task automatic model_close(input bit t);
    m_collect   = 1'b0;
    m_tmo       = t;
    m_rv_edge   = edge_cnt + 2;
    m_idle_edge = edge_cnt + 3;
  endtask

  task automatic step(input bit st, input bit bv, input int id, input bit bval);
    bit exp_err;
    bit all;
    start        = st;
    ballot_valid = bv;
    ballot_id    = id[2:0];
    ballot_val   = bval;
    @(posedge clk);
    edge_cnt++;
    exp_err = 1'b0;
    if (m_collect) begin
      if (bv) begin
        if (id >= NV) exp_err = 1'b1;
        else if (m_got[id]) exp_err = 1'b1;
        else begin
          m_got[id] = 1'b1;
          m_val[id] = bval;
        end
      end
      all = 1'b1;
      for (int i = 0; i < NV; i++) all = all & m_got[i];
      if (all) model_close(1'b0);
      else if (m_age == TMO - 1) model_close(1'b1);
      else m_age++;
    end else if (st && edge_cnt >= m_idle_edge) begin
      m_collect = 1'b1;
      m_age     = 0;
      m_tmo     = 1'b0;
      model_clear();
    end
    #1;
    check_eq("ballot_ready", int'(ballot_ready), int'(m_collect));
    check_eq("err", int'(err), int'(exp_err));
    check_eq("result_valid", int'(result_valid), int'(edge_cnt == m_rv_edge));
    check_eq("vote", int'(vote), model_vote());
    if (edge_cnt == m_rv_edge) begin
      check_eq("yes_count", int'(yes_count), model_yes());
      check_eq("pass", int'(pass), int'(model_yes() >= 4));
      check_eq("timed_out", int'(timed_out), int'(m_tmo));
    end
    start        = 1'b0;
    ballot_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", int'(ballot_ready), 0);
    check_eq("rst_vote", int'(vote), 0);
    check_eq("rst_yes", int'(yes_count), 0);
    check_eq("rst_pass", int'(pass), 0);
    check_eq("rst_rv", int'(result_valid), 0);
    check_eq("rst_tmo", int'(timed_out), 0);
    check_eq("rst_err", int'(err), 0);
    model_clear();
    m_collect   = 1'b0;
    m_tmo       = 1'b0;
    m_rv_edge   = -10;
    m_idle_edge = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic full_session(input bit [6:0] vals);
    step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < NV; i++) step(1'b0, 1'b1, i, vals[i]);
    idle(3);
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Ids 0..6 voting 1,1,1,1,0,0,0.
    full_session(7'b0001111);
    check_eq("d_pass_vote", int'(vote), 'h0F);
    check_eq("d_pass_yes", int'(yes_count), 4);
    check_eq("d_pass_pass", int'(pass), 1);
    check_eq("d_pass_tmo", int'(timed_out), 0);

    // One yes short of passing.
    full_session(7'b0000111);
    check_eq("d_fail_yes", int'(yes_count), 3);
    check_eq("d_fail_pass", int'(pass), 0);
    check_eq("d_fail_tmo", int'(timed_out), 0);

    // Partial session closed by timeout.
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b1);
    step(1'b0, 1'b1, 2, 1'b1);
    step(1'b0, 1'b1, 4, 1'b1);
    idle(TMO + 2);
    check_eq("d_tmo_flag", int'(timed_out), 1);
    check_eq("d_tmo_yes", int'(yes_count), 3);
    check_eq("d_tmo_pass", int'(pass), 0);
    check_eq("d_tmo_vote", int'(vote), 'h15);

    // Duplicate id and illegal id are both rejected.
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 3, 1'b1);
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b0, 1'b1, 7, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);
    check_eq("d_dup_vote", int'(vote), 'h08);
    idle(TMO + 2);

    // Reset in the middle of a session, then a clean session.
    step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i, 1'b1);
    do_reset();
    full_session(7'b0101010);
    check_eq("d_rst_vote", int'(vote), 'h2A);
    check_eq("d_rst_yes", int'(yes_count), 3);

    // Seventh ballot lands on the final timeout cycle.
    step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i, 1'b1);
    idle(TMO - 7);
    step(1'b0, 1'b1, 6, 1'b1);
    idle(3);
    check_eq("d_race_tmo", int'(timed_out), 0);
    check_eq("d_race_yes", int'(yes_count), 7);
    check_eq("d_race_vote", int'(vote), 'h7F);

    // Randomized sessions with stray starts, bad ids and occasional resets.
    for (int s = 0; s < 40; s++) begin
      int rate;
      rate = (s % 2 == 0) ? 9 : 6;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 0, 1'b0);
      for (int c = 0; c < 24; c++) begin
        if (s % 7 == 3 && c == 5) do_reset();
        else step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < rate),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
